// File: rtl/seq_alu.sv
// seq_alu: multi-cycle integer ALU with valid/ready handshakes.
// Single-cycle logic, compare and add/sub ops complete in one cycle.
// MUL/MULHU/DIVU/REMU iterate one bit per cycle for WIDTH cycles.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  input  logic [CBITS-1:0] control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CBITS-1:0] OP_AND  = CBITS'(4'b0000);
  localparam logic [CBITS-1:0] OP_OR   = CBITS'(4'b0001);
  localparam logic [CBITS-1:0] OP_ADD  = CBITS'(4'b0010);
  localparam logic [CBITS-1:0] OP_XOR  = CBITS'(4'b0011);
  localparam logic [CBITS-1:0] OP_SLTU = CBITS'(4'b0101);
  localparam logic [CBITS-1:0] OP_SUB  = CBITS'(4'b0110);
  localparam logic [CBITS-1:0] OP_SLT  = CBITS'(4'b0111);
  localparam logic [CBITS-1:0] OP_NOR  = CBITS'(4'b1100);

  // Low two bits of a multi-cycle code select the flavour.
  localparam logic [1:0] MC_MUL   = 2'b00;
  localparam logic [1:0] MC_MULHU = 2'b01;
  localparam logic [1:0] MC_DIVU  = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               div0_q, div0_d;

  logic [WIDTH-1:0]   alu_c;
  logic               is_multi_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [2*WIDTH-1:0] mul_next_c;
  logic [WIDTH:0]     div_shift_c;
  logic [WIDTH:0]     div_diff_c;
  logic               div_ge_c;
  logic [WIDTH-1:0]   quo_next_c;
  logic [WIDTH-1:0]   rem_next_c;
  logic [WIDTH-1:0]   calc_res_c;

  // Single-cycle result from the live operands.
  always_comb begin
    alu_c = '0;
    case (control)
      OP_AND:  alu_c = first & second;
      OP_OR:   alu_c = first | second;
      OP_ADD:  alu_c = first + second;
      OP_XOR:  alu_c = first ^ second;
      OP_SLTU: alu_c = WIDTH'(first < second);
      OP_SUB:  alu_c = first - second;
      OP_SLT:  alu_c = WIDTH'($signed(first) < $signed(second));
      OP_NOR:  alu_c = ~(first | second);
      default: alu_c = '0;
    endcase
  end

  assign is_multi_c = (control[CBITS-1:CBITS-2] == 2'b10);

  // One shift-add multiply step: hi half accumulates B, whole pair shifts right.
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};
  end

  // One restoring divide step: quotient bits shift in at the bottom of acc_q.
  always_comb begin
    div_shift_c = {rem_q, acc_q[WIDTH-1]};
    div_diff_c  = div_shift_c - {1'b0, opb_q};
    div_ge_c    = ~div_diff_c[WIDTH];
    quo_next_c  = {acc_q[WIDTH-2:0], div_ge_c};
    rem_next_c  = div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
  end

  // Final multi-cycle result, with the divide-by-zero results forced.
  always_comb begin
    calc_res_c = '0;
    case (op_q)
      MC_MUL:   calc_res_c = mul_next_c[WIDTH-1:0];
      MC_MULHU: calc_res_c = mul_next_c[2*WIDTH-1:WIDTH];
      MC_DIVU:  calc_res_c = div0_q ? '1 : quo_next_c;
      default:  calc_res_c = div0_q ? opa_q : rem_next_c;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    div0_d   = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_multi_c) begin
            acc_d   = {WIDTH'(0), first};
            rem_d   = '0;
            opa_d   = first;
            opb_d   = second;
            cnt_d   = '0;
            op_d    = control[1:0];
            div0_d  = (second == '0);
            state_d = ST_CALC;
          end else begin
            result_d = alu_c;
            state_d  = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        if (op_q[1]) begin
          acc_d = {WIDTH'(0), quo_next_c};
          rem_d = rem_next_c;
        end else begin
          acc_d = mul_next_c;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = calc_res_c;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      div0_q   <= div0_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule
